mem_access_sequencer: RTL



---
 rtl/mem_seq_pkg.sv | 16 +
 rtl/mem_access_sequencer_arb.sv | 23 ++
 rtl/mem_access_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory access sequencer: FSM states, requester ids
// and wait-state counter width.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/mem_access_sequencer_arb.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// requester that did not win last time is granted.
module rr_arbiter_2
  import mem_seq_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    grant       = REQ_CORE;
    case (req)
      2'b01:   grant = REQ_CORE;
      2'b10:   grant = REQ_LOADER;
      2'b11:   grant = ~last_grant;
      default: grant = REQ_CORE;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Shares the single memory port between the core and the program loader,
// inserting WAIT_CYCLES wait states and returning a one-cycle ready pulse.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_ready,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_ready,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  gid_q, gid_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_WIDTH-1:0] l_rdata_q, l_rdata_d;
  logic                  c_ready_q, c_ready_d;
  logic                  l_ready_q, l_ready_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  logic                  busy_q, busy_d;

  logic grant;
  logic grant_valid;

  rr_arbiter_2 u_arb (
    .req         ({l_req, c_req}),
    .last_grant  (last_grant_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Memory strobes are registered, so they are computed for the state being
  // entered: the cycle that will have counter==0 is the one that writes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    c_rdata_d    = c_rdata_q;
    l_rdata_d    = l_rdata_q;
    c_ready_d    = 1'b0;
    l_ready_d    = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          gid_d        = grant;
          last_grant_d = grant;
          if (grant == REQ_LOADER) begin
            we_d    = l_we;
            addr_d  = l_addr;
            wdata_d = l_wdata;
          end else begin
            we_d    = c_we;
            addr_d  = c_addr;
            wdata_d = c_wdata;
          end
          cnt_d       = WAIT_W'(WAIT_CYCLES);
          state_d     = S_ACCESS;
          mem_addr_d  = addr_d;
          mem_wdata_d = wdata_d;
          mem_re_d    = ~we_d;
          mem_we_d    = we_d && (WAIT_CYCLES == 0);
        end
      end

      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d       = cnt_q - WAIT_W'(1);
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          mem_re_d    = ~we_q;
          mem_we_d    = we_q && (cnt_q == WAIT_W'(1));
        end else begin
          state_d = S_DONE;
          if (gid_q == REQ_LOADER) begin
            l_ready_d = 1'b1;
            if (!we_q) l_rdata_d = mem_rdata;
          end else begin
            c_ready_d = 1'b1;
            if (!we_q) c_rdata_d = mem_rdata;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= REQ_LOADER;
      gid_q        <= REQ_CORE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      c_rdata_q    <= '0;
      l_rdata_q    <= '0;
      c_ready_q    <= 1'b0;
      l_ready_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      c_rdata_q    <= c_rdata_d;
      l_rdata_q    <= l_rdata_d;
      c_ready_q    <= c_ready_d;
      l_ready_q    <= l_ready_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
    end
  end

  assign c_ready   = c_ready_q;
  assign c_rdata   = c_rdata_q;
  assign l_ready   = l_ready_q;
  assign l_rdata   = l_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;

endmodule
